// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer family: FSM state encodings and default timing.
package debounce_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 50000;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; all stages clear to 0 on reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/level_debouncer.sv
// Debounces a raw asynchronous input into a clean registered level; a change is accepted
// only after the synchronized input disagrees with the current level for STABLE_CYCLES+1 samples.
module level_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy_in,
  output logic level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_in;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (noisy_in),
    .q       (sync_in)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_ZERO;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

  // The abort test comes first in each WAIT state, so a disagreeing sample always wins over terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    case (state)
      ST_ZERO: begin
        if (sync_in) begin
          state_nxt = ST_WAIT1;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT1: begin
        if (!sync_in) begin
          state_nxt = ST_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ONE;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_ONE: begin
        if (!sync_in) begin
          state_nxt = ST_WAIT0;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT0: begin
        if (sync_in) begin
          state_nxt = ST_ONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ZERO;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_ZERO;
      end
    endcase
  end

  // Decoded straight from the state register so it cannot glitch.
  assign busy = (state == ST_WAIT1) || (state == ST_WAIT0);

endmodule

// File: tb/tb_level_debouncer.sv
// Bench for level_debouncer: directed scenarios plus random bursts, checked against a
// run-length model (level flips once STABLE+1 consecutive synchronized samples disagree with it).
module tb_level_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic noisy_in = 1'b0;
  logic level;
  logic busy;

  int n_vec = 0;
  int n_err = 0;

  bit pipe [SYNC];
  int run_len;
  bit mdl_level;

  level_debouncer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .noisy_in (noisy_in),
    .level    (level),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pipe[i]) pipe[i] = 1'b0;
    run_len   = 0;
    mdl_level = 1'b0;
  endtask

  // Input reaches the FSM SYNC edges late; each disagreeing sample extends the run, agreement clears it.
  task automatic model_step(input bit v);
    bit samp;
    samp = pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = v;
    if (samp != mdl_level) begin
      run_len++;
      if (run_len == STABLE + 1) begin
        mdl_level = samp;
        run_len   = 0;
      end
    end else begin
      run_len = 0;
    end
  endtask

  task automatic apply_stimulus(input bit v, input string tag);
    noisy_in = v;
    @(posedge clk);
    model_step(v);
    #1;
    check_output({tag, "_level"}, level, mdl_level);
    check_output({tag, "_busy"}, busy, run_len > 0);
  endtask

  initial begin
    int   rises;
    logic prev;
    bit   v;
    int   len;

    model_reset();
    #12;
    check_output("reset_level", level, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, "idle");

    // Clean rise: level changes exactly at edge 7, busy spans edges 3..6
    for (int i = 1; i <= 9; i++) begin
      apply_stimulus(1'b1, "rise");
      if (i == 2) check_output("rise_busy_e2", busy, 1'b0);
      if (i == 3) check_output("rise_busy_e3", busy, 1'b1);
      if (i == 6) check_output("rise_level_e6", level, 1'b0);
      if (i == 7) begin
        check_output("rise_level_e7", level, 1'b1);
        check_output("rise_busy_e7", busy, 1'b0);
      end
    end

    // Clean fall
    for (int i = 1; i <= 9; i++) begin
      apply_stimulus(1'b0, "fall");
      if (i == 3) check_output("fall_busy_e3", busy, 1'b1);
      if (i == 6) check_output("fall_level_e6", level, 1'b1);
      if (i == 7) check_output("fall_level_e7", level, 1'b0);
    end

    // Threshold: a 5-cycle pulse is accepted
    for (int i = 1; i <= 18; i++) begin
      apply_stimulus(i <= 5, "pulse5");
      if (i == 6) check_output("pulse5_level_e6", level, 1'b0);
      if (i == 7) check_output("pulse5_level_e7", level, 1'b1);
    end

    // Threshold: a 4-cycle pulse is rejected
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(i <= 4, "pulse4");
      check_output("pulse4_level", level, 1'b0);
      if (i == 6) check_output("pulse4_busy_e6", busy, 1'b1);
      if (i == 7) check_output("pulse4_busy_e7", busy, 1'b0);
    end

    // Bounce then hold: exactly one rising transition
    rises = 0;
    prev  = level;
    for (int i = 0; i < 20; i++) begin
      v = (i < 6) ? ((6'b101101 >> (5 - i)) & 1) != 0 : 1'b1;
      apply_stimulus(v, "bounce");
      if (level && !prev) rises++;
      prev = level;
    end
    check_output("bounce_one_rise", rises == 1, 1'b1);

    // Glitch during WAIT0 returns to ONE, then the fall qualifies afresh
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(i != 3, "glitch") ;
    end
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(i == 3, "glitch0");
      if (i == 4) check_output("glitch_busy_e4", busy, 1'b1);
      if (i == 5) begin
        check_output("glitch_busy_e5", busy, 1'b0);
        check_output("glitch_level_e5", level, 1'b1);
      end
      if (i == 9)  check_output("glitch_level_e9", level, 1'b1);
      if (i == 10) check_output("glitch_level_e10", level, 1'b0);
    end

    // Reset mid-qualify (WAIT1 with cnt=2) clears outputs without a clock edge
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, "prereset");
    check_output("prereset_busy", busy, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_output("midreset_level", level, 1'b0);
    check_output("midreset_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      apply_stimulus(1'b1, "postreset");
      if (i == 6) check_output("postreset_level_e6", level, 1'b0);
      if (i == 7) check_output("postreset_level_e7", level, 1'b1);
    end

    // Long hold high
    for (int i = 0; i < 1000; i++) apply_stimulus(1'b1, "hold");
    check_output("hold_level", level, 1'b1);
    check_output("hold_busy", busy, 1'b0);

    // Random bursts of varying length
    for (int s = 0; s < 120; s++) begin
      v   = $urandom_range(0, 1) != 0;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) apply_stimulus(v, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
